// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmitter and receiver
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, WAIT_CLK, XFER, ACK, WAIT_IDLE, ABORT} state_t;
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NORESP  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_NACK    = 2'b11;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;
    // {stop, odd parity, data}, shifted out LSB first
    function automatic logic [9:0] build_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer plus falling-edge detect for one PS/2 line
module ps2_line_sync (
    input  logic clk,
    input  logic rstin,
    input  logic din,
    output logic level,
    output logic fall
);
    logic meta, prev;
    // idle bus is high, so reset to 1 to avoid a false edge after reset
    always_ff @(posedge clk or negedge rstin)
        if (!rstin) {meta, level, prev} <= 3'b111;
        else {meta, level, prev} <= {din, meta, level};
    assign fall = prev & ~level;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with request-to-send,
// device ACK check and timeouts; pads driven through open-drain enables
module ps2_host_tx import ps2_pkg::*; #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int SETUP_CYCLES   = 250,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       clk,
    input  logic       rstin,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code
);
    localparam int CMAX = (START_TIMEOUT > INHIBIT_CYCLES)
        ? ((START_TIMEOUT > SETUP_CYCLES) ? START_TIMEOUT : SETUP_CYCLES)
        : ((INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES);
    localparam int CW = $clog2(CMAX + 1);
    localparam int XW = $clog2(XFER_TIMEOUT + 1);
    state_t state;
    logic [CW-1:0] cnt;
    logic [XW-1:0] xt;
    logic [9:0] frame;
    logic [3:0] bit_cnt;
    logic clk_s, clk_fall, data_s, data_fall_unused, xt_exp;
    ps2_line_sync u_clk_sync (.clk(clk), .rstin(rstin), .din(ps2_clk_in), .level(clk_s), .fall(clk_fall));
    ps2_line_sync u_data_sync (.clk(clk), .rstin(rstin), .din(ps2_data_in), .level(data_s), .fall(data_fall_unused));
    assign xt_exp = xt == XW'(XFER_TIMEOUT - 1);
    always_ff @(posedge clk or negedge rstin) begin
        if (!rstin) begin
            state <= IDLE;
            cnt <= '0;
            xt <= '0;
            frame <= '0;
            bit_cnt <= '0;
            {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error} <= '0;
            err_code <= ERR_NONE;
        end else begin
            tx_done <= 1'b0;
            tx_error <= 1'b0;
            // the transfer timer spans XFER, ACK and WAIT_IDLE; expiry wins over any edge
            if (state inside {XFER, ACK, WAIT_IDLE} && xt_exp) begin
                {ps2_clk_oe, ps2_data_oe, tx_busy, tx_error} <= 4'b0001;
                err_code <= ERR_TIMEOUT;
                state <= ABORT;
            end else begin
                if (state inside {XFER, ACK, WAIT_IDLE}) xt <= xt + XW'(1);
                case (state)
                    IDLE: if (tx_start && !tx_done) begin
                        frame <= build_frame(tx_data);
                        tx_busy <= 1'b1;
                        err_code <= ERR_NONE;
                        ps2_clk_oe <= 1'b1;
                        cnt <= '0;
                        state <= INHIBIT;
                    end
                    INHIBIT: if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                        cnt <= '0;
                        ps2_data_oe <= 1'b1;
                        state <= RTS;
                    end else cnt <= cnt + CW'(1);
                    RTS: if (cnt == CW'(SETUP_CYCLES - 1)) begin
                        cnt <= '0;
                        ps2_clk_oe <= 1'b0;
                        state <= WAIT_CLK;
                    end else cnt <= cnt + CW'(1);
                    WAIT_CLK: if (clk_fall) begin
                        ps2_data_oe <= ~frame[0];
                        frame <= {1'b1, frame[9:1]};
                        bit_cnt <= 4'd1;
                        xt <= '0;
                        state <= XFER;
                    end else if (cnt == CW'(START_TIMEOUT - 1)) begin
                        {ps2_clk_oe, ps2_data_oe, tx_busy, tx_error} <= 4'b0001;
                        err_code <= ERR_NORESP;
                        state <= ABORT;
                    end else cnt <= cnt + CW'(1);
                    XFER: if (clk_fall) begin
                        ps2_data_oe <= ~frame[0];
                        frame <= {1'b1, frame[9:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd9) state <= ACK;
                    end
                    ACK: if (clk_fall) begin
                        if (data_s) begin
                            {ps2_clk_oe, ps2_data_oe, tx_busy, tx_error} <= 4'b0001;
                            err_code <= ERR_NACK;
                            state <= ABORT;
                        end else state <= WAIT_IDLE;
                    end
                    WAIT_IDLE: if (clk_s && data_s) begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a wired-AND pad model and a simple PS/2 device
module tb_ps2_host_tx;
    localparam int INH = 60, SET = 25, ST = 300, XT = 600, H = 20;
    logic clk = 1'b0, rstin = 1'b0, tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic dev_clk = 1'b1, dev_data = 1'b1;
    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;
    logic [1:0] err_code;
    int total = 0, bad = 0, cyc = 0, n_done = 0, n_err = 0, n_both = 0, err_cyc = 0;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .START_TIMEOUT(ST), .XFER_TIMEOUT(XT)) dut (
        .clk(clk), .rstin(rstin), .tx_start(tx_start), .tx_data(tx_data),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error), .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (tx_done) n_done <= n_done + 1;
        if (tx_error) begin
            n_err <= n_err + 1;
            err_cyc <= cyc;
        end
        if (tx_done && tx_error) n_both <= n_both + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        tx_data = d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    // counts cycles with clk_oe high and the first cycle data_oe is high (1-based)
    task automatic preamble(output int lo, output int dfirst);
        lo = 0;
        dfirst = 0;
        while (ps2_clk_oe && lo < 20000) begin
            lo++;
            if (ps2_data_oe && dfirst == 0) dfirst = lo;
            tick();
        end
    endtask

    task automatic dev_pulse(output logic b);
        dev_clk = 1'b0;
        repeat (H) tick();
        dev_clk = 1'b1;
        b = ps2_data_in;
        repeat (H) tick();
    endtask

    task automatic send_frame(input logic ack, output logic [9:0] bits, output logic start_bit);
        logic b;
        start_bit = ps2_data_in;
        repeat (H) tick();
        for (int i = 0; i < 10; i++) begin
            dev_pulse(b);
            bits[i] = b;
        end
        dev_data = ack;
        dev_pulse(b);
        dev_data = 1'b1;
    endtask

    task automatic wait_evt(input int d0, input int e0, input int lim);
        int k = 0;
        while (n_done == d0 && n_err == e0 && k < lim) begin
            tick();
            k++;
        end
        chk("evt_wait", 32'(k < lim), 32'd1);
        repeat (3) tick();
    endtask

    task automatic good_frame(input logic [7:0] d, input logic [9:0] exp_frame, input string tag);
        int lo, df, d0, e0;
        logic [9:0] bits;
        logic sb;
        d0 = n_done;
        e0 = n_err;
        start_tx(d);
        chk({tag, "_busy"}, 32'(tx_busy), 32'd1);
        preamble(lo, df);
        chk({tag, "_clk_low"}, 32'(lo), 32'(INH + SET));
        chk({tag, "_data_first"}, 32'(df), 32'(INH + 1));
        send_frame(1'b0, bits, sb);
        wait_evt(d0, e0, 2000);
        chk({tag, "_start_bit"}, 32'(sb), 32'd0);
        chk({tag, "_frame"}, 32'(bits), 32'(exp_frame));
        chk({tag, "_done_cnt"}, 32'(n_done - d0), 32'd1);
        chk({tag, "_err_cnt"}, 32'(n_err - e0), 32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
        chk({tag, "_idle"}, {29'd0, tx_busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    initial begin
        int lo, df, d0, e0, t0, k;
        logic [9:0] bits;
        logic sb, b;
        repeat (3) tick();
        chk("rst_outputs", {26'd0, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error, 1'b0}, 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        rstin = 1'b1;
        repeat (3) tick();

        good_frame(8'hED, 10'h3ED, "ed");
        good_frame(8'hF4, 10'h2F4, "f4");
        good_frame(8'h00, 10'h300, "z00");

        // device never clocks
        d0 = n_done;
        e0 = n_err;
        start_tx(8'hF4);
        preamble(lo, df);
        t0 = cyc;
        wait_evt(d0, e0, 2000);
        chk("noresp_time", 32'(err_cyc - t0), 32'(ST));
        chk("noresp_code", 32'(err_code), 32'd1);
        chk("noresp_pads", {29'd0, tx_busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("noresp_done", 32'(n_done - d0), 32'd0);

        // device stops after four clocks
        d0 = n_done;
        e0 = n_err;
        start_tx(8'hED);
        preamble(lo, df);
        repeat (H) tick();
        t0 = cyc;
        for (int i = 0; i < 4; i++) dev_pulse(b);
        wait_evt(d0, e0, 2000);
        chk("xfer_to_time", 32'(err_cyc - t0), 32'(XT + 3));
        chk("xfer_to_code", 32'(err_code), 32'd2);
        chk("xfer_to_pads", {29'd0, tx_busy, ps2_clk_oe, ps2_data_oe}, 32'd0);

        // device leaves data high at the ACK clock
        d0 = n_done;
        e0 = n_err;
        start_tx(8'hF4);
        preamble(lo, df);
        send_frame(1'b1, bits, sb);
        wait_evt(d0, e0, 2000);
        chk("nack_err", 32'(n_err - e0), 32'd1);
        chk("nack_done", 32'(n_done - d0), 32'd0);
        chk("nack_code", 32'(err_code), 32'd3);

        // asynchronous reset in the middle of the data bits
        start_tx(8'hED);
        preamble(lo, df);
        repeat (H) tick();
        for (int i = 0; i < 3; i++) dev_pulse(b);
        dev_clk = 1'b0;
        repeat (2) tick();
        chk("pre_rst_busy", 32'(tx_busy), 32'd1);
        #1 rstin = 1'b0;
        #1 chk("mid_rst_pads", {29'd0, tx_busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
        dev_clk = 1'b1;
        repeat (3) tick();
        rstin = 1'b1;
        repeat (3) tick();

        // 0xFF with tx_start held high throughout, including the done cycle
        d0 = n_done;
        start_tx(8'hFF);
        preamble(lo, df);
        tx_data = 8'h00;
        tx_start = 1'b1;
        send_frame(1'b0, bits, sb);
        k = 0;
        while (!tx_done && k < 200) begin
            tick();
            k++;
        end
        chk("ff_done_seen", 32'(tx_done), 32'd1);
        tick();
        tx_start = 1'b0;
        tick();
        chk("ff_no_restart", {30'd0, tx_busy, ps2_clk_oe}, 32'd0);
        repeat (50) tick();
        chk("ff_frame", 32'(bits), 32'h3FF);
        chk("ff_one_done", 32'(n_done - d0), 32'd1);
        chk("ff_still_idle", {30'd0, tx_busy, ps2_clk_oe}, 32'd0);
        chk("never_both", 32'(n_both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
